// File: rtl/x_pkg.sv
// Shared definitions for the X interface and the blocks behind it.
package x_pkg;

    // Default data width for din/dout and the countdown counter.
    localparam int X_WIDTH = 8;

    // Countdown controller states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } x_state_e;

endpackage : x_pkg

// File: rtl/x_countdown.sv
// Loadable down-counter/timer with terminal-count pulse and optional
// auto-reload for periodic operation. All outputs are registered.
module x_countdown
    import x_pkg::*;
#(
    parameter int WIDTH       = X_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    x_state_e         state_r;
    x_state_e         state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_s;
    logic             busy_r;
    logic             busy_s;
    logic             tc_r;
    logic             tc_s;

    // Next-state logic: load has priority over counting; tc defaults low so it is a single-cycle pulse.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        reload_s = reload_r;
        busy_s   = busy_r;
        tc_s     = 1'b0;
        if (load) begin
            if (din != ZERO) begin
                // Start (or restart) a run; an aborted run never produces tc.
                cnt_s    = din;
                reload_s = din;
                state_s  = RUN;
                busy_s   = 1'b1;
                tc_s     = 1'b0;
            end else begin
                // A zero load is an immediate terminal count, even with auto-reload.
                cnt_s    = ZERO;
                reload_s = ZERO;
                state_s  = IDLE;
                busy_s   = 1'b0;
                tc_s     = 1'b1;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (cnt_r > ONE) begin
                        cnt_s = cnt_r - ONE;
                        tc_s  = 1'b0;
                    end else begin
                        // Terminal: count is 1 here, RUN never holds a zero count.
                        tc_s = 1'b1;
                        if (AUTO_RELOAD) begin
                            cnt_s = reload_r;
                        end else begin
                            cnt_s   = ZERO;
                            state_s = IDLE;
                            busy_s  = 1'b0;
                        end
                    end
                end
                IDLE: begin
                    tc_s = 1'b0;
                end
                default: begin
                    cnt_s   = ZERO;
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    tc_s    = 1'b0;
                end
            endcase
        end
    end

    // State, counter, reload value and output flags; asynchronous clear on reset_l low.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_r  <= IDLE;
            cnt_r    <= ZERO;
            reload_r <= ZERO;
            busy_r   <= 1'b0;
            tc_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            reload_r <= reload_s;
            busy_r   <= busy_s;
            tc_r     <= tc_s;
        end
    end

    assign dout = cnt_r;
    assign busy = busy_r;
    assign tc   = tc_r;

endmodule : x_countdown
